// File: rtl/sat_integrator.sv
// -----------------------------------------------------------------------------
// sat_integrator
//
// Saturating, anti-windup integrator for the controller I-path. It accumulates
// the signed error samples coming from the saturated add/sub block and presents
// a scaled, clamped version of the accumulator two cycles later.
//
//   Stage 1 : acc_q <= clamp(acc_q + in_data, lim_lo, lim_hi)
//             sat flags and ov_sticky are registered alongside the accumulator.
//   Stage 2 : out_data <= clamp(acc_q >>> SHIFT) to the N_OUT signed range.
//             out_valid follows the stage-1 valid one cycle later.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active high
//   in_valid   in   1      in_data / in_ov qualified this cycle
//   in_data    in   N_IN   signed error sample
//   in_ov      in   1      upstream saturation flag
//   clr        in   1      synchronous accumulator clear
//   hold       in   1      freeze the accumulator
//   lim_hi     in   N_ACC  signed upper accumulator limit
//   lim_lo     in   N_ACC  signed lower accumulator limit
//   out_valid  out  1      out_data qualified
//   out_data   out  N_OUT  signed clamp(acc >>> SHIFT)
//   sat_hi     out  1      accumulator was clamped at lim_hi by the update
//   sat_lo     out  1      accumulator was clamped at lim_lo by the update
//   ov_sticky  out  1      an accepted sample carried in_ov since clr/rst
//   cfg_err    out  1      registered lim_lo > lim_hi
// -----------------------------------------------------------------------------
module sat_integrator #(
   parameter int N_IN  = 16,
   parameter int N_ACC = 24,
   parameter int N_OUT = 16,
   parameter int SHIFT = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic signed [N_IN-1:0]  in_data,
   input  logic                    in_ov,
   input  logic                    clr,
   input  logic                    hold,
   input  logic signed [N_ACC-1:0] lim_hi,
   input  logic signed [N_ACC-1:0] lim_lo,
   output logic                    out_valid,
   output logic signed [N_OUT-1:0] out_data,
   output logic                    sat_hi,
   output logic                    sat_lo,
   output logic                    ov_sticky,
   output logic                    cfg_err
);

   // One guard bit is enough for acc + sample since N_IN <= N_ACC.
   localparam int NS = N_ACC + 1;
   // Wide enough that the shifted accumulator can be compared against the
   // output range without any truncation, whatever N_ACC/N_OUT/SHIFT are.
   localparam int NW = N_ACC + N_OUT + 1;

   localparam logic signed [NW-1:0] OUT_MAX_W = {{(NW-N_OUT+1){1'b0}}, {(N_OUT-1){1'b1}}};
   localparam logic signed [NW-1:0] OUT_MIN_W = {{(NW-N_OUT+1){1'b1}}, {(N_OUT-1){1'b0}}};
   localparam logic signed [N_OUT-1:0] OUT_MAX = {1'b0, {(N_OUT-1){1'b1}}};
   localparam logic signed [N_OUT-1:0] OUT_MIN = {1'b1, {(N_OUT-1){1'b0}}};

   // ---------------------------------------------------------------------------
   // Stage 1 state
   // ---------------------------------------------------------------------------
   logic signed [N_ACC-1:0] acc_q,    acc_d;
   logic                    sat_hi_q, sat_hi_d;
   logic                    sat_lo_q, sat_lo_d;
   logic                    ov_q,     ov_d;
   logic                    s1_valid_q;
   logic                    cfg_err_q;

   // ---------------------------------------------------------------------------
   // Stage 2 state
   // ---------------------------------------------------------------------------
   logic                    out_valid_q;
   logic signed [N_OUT-1:0] out_data_q, out_data_d;
   logic                    out_sat_hi_q;
   logic                    out_sat_lo_q;

   // ---------------------------------------------------------------------------
   // Stage 1 datapath: widened sum, then clamp to the limits. Clamping the sum
   // (not the previous accumulator) is what gives anti-windup: the first sample
   // of opposite sign moves the accumulator off the rail immediately.
   // ---------------------------------------------------------------------------
   logic signed [NS-1:0] sum_w;
   logic signed [NS-1:0] hi_w;
   logic signed [NS-1:0] lo_w;
   logic                 cfg_bad;

   assign sum_w   = {acc_q[N_ACC-1], acc_q} + {{(NS-N_IN){in_data[N_IN-1]}}, in_data};
   assign hi_w    = {lim_hi[N_ACC-1], lim_hi};
   assign lo_w    = {lim_lo[N_ACC-1], lim_lo};
   assign cfg_bad = (lim_lo > lim_hi);

   // Priority: clr > cfg error > hold > sample accept (rst handled in the flop).
   always_comb begin
      acc_d    = acc_q;
      sat_hi_d = sat_hi_q;
      sat_lo_d = sat_lo_q;
      ov_d     = ov_q;
      if (clr) begin
         acc_d    = '0;
         sat_hi_d = 1'b0;
         sat_lo_d = 1'b0;
         ov_d     = 1'b0;
      end else if (cfg_bad) begin
         // Inconsistent limits: park the accumulator at zero, drop the sample.
         acc_d    = '0;
         sat_hi_d = 1'b0;
         sat_lo_d = 1'b0;
      end else if (hold) begin
         acc_d    = acc_q;
      end else if (in_valid) begin
         if (sum_w > hi_w) begin
            acc_d    = lim_hi;
            sat_hi_d = 1'b1;
            sat_lo_d = 1'b0;
         end else if (sum_w < lo_w) begin
            acc_d    = lim_lo;
            sat_hi_d = 1'b0;
            sat_lo_d = 1'b1;
         end else begin
            acc_d    = sum_w[N_ACC-1:0];
            sat_hi_d = 1'b0;
            sat_lo_d = 1'b0;
         end
         if (in_ov) begin
            ov_d = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stage 2 datapath: arithmetic (floor) shift, then clamp to N_OUT range.
   // ---------------------------------------------------------------------------
   logic signed [NW-1:0] acc_ext;
   logic signed [NW-1:0] acc_sh;

   assign acc_ext = {{(NW-N_ACC){acc_q[N_ACC-1]}}, acc_q};
   assign acc_sh  = acc_ext >>> SHIFT;

   always_comb begin
      out_data_d = acc_sh[N_OUT-1:0];
      if (acc_sh > OUT_MAX_W) begin
         out_data_d = OUT_MAX;
      end else if (acc_sh < OUT_MIN_W) begin
         out_data_d = OUT_MIN;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q        <= '0;
         sat_hi_q     <= 1'b0;
         sat_lo_q     <= 1'b0;
         ov_q         <= 1'b0;
         s1_valid_q   <= 1'b0;
         cfg_err_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_sat_hi_q <= 1'b0;
         out_sat_lo_q <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         sat_hi_q   <= sat_hi_d;
         sat_lo_q   <= sat_lo_d;
         ov_q       <= ov_d;
         // A sample still produces an output slot when clr/cfg/hold swallowed
         // it; the slot then carries whatever the accumulator became.
         s1_valid_q <= in_valid;
         cfg_err_q  <= cfg_bad;

         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_data_q   <= out_data_d;
            out_sat_hi_q <= sat_hi_q;
            out_sat_lo_q <= sat_lo_q;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign sat_hi    = out_sat_hi_q;
   assign sat_lo    = out_sat_lo_q;
   assign ov_sticky = ov_q;
   assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_sat_integrator.sv
// -----------------------------------------------------------------------------
// tb_sat_integrator
//
// Scoreboard bench for sat_integrator. Every cycle the step task first looks at
// the DUT outputs (on the falling edge), then drives the next inputs and runs a
// behavioural model of the integrator; accepted slots push their expected
// output into a queue that the output side pops.
// -----------------------------------------------------------------------------
module tb_sat_integrator;

   localparam longint LIM_MAX = 64'sd8388607;
   localparam longint LIM_MIN = -64'sd8388608;

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic signed [15:0] in_data;
   logic               in_ov;
   logic               clr;
   logic               hold;
   logic signed [23:0] lim_hi;
   logic signed [23:0] lim_lo;
   logic               out_valid;
   logic signed [15:0] out_data;
   logic               sat_hi;
   logic               sat_lo;
   logic               ov_sticky;
   logic               cfg_err;

   sat_integrator #(
      .N_IN (16),
      .N_ACC(24),
      .N_OUT(16),
      .SHIFT(8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ov    (in_ov),
      .clr      (clr),
      .hold     (hold),
      .lim_hi   (lim_hi),
      .lim_lo   (lim_lo),
      .out_valid(out_valid),
      .out_data (out_data),
      .sat_hi   (sat_hi),
      .sat_lo   (sat_lo),
      .ov_sticky(ov_sticky),
      .cfg_err  (cfg_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      longint d;
      bit     sh;
      bit     sl;
      int     cyc;
   } exp_t;

   exp_t   sb_q[$];
   int     n_vec     = 0;
   int     n_miscmp  = 0;
   int     cyc       = 0;

   // Reference model state
   longint m_acc     = 0;
   bit     m_sh      = 0;
   bit     m_sl      = 0;
   bit     m_ov      = 0;
   bit     m_cfg     = 0;
   longint hi_l      = LIM_MAX;
   longint lo_l      = LIM_MIN;

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_vec++;
      if (obs != exp) begin
         n_miscmp++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic longint out_scale(input longint acc);
      longint s;
      s = acc >>> 8;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      return s;
   endfunction

   // One clock: observe outputs, then drive the next input set and model it.
   task automatic step(input bit r, input bit v, input longint d,
                       input bit o, input bit c, input bit h);
      exp_t   e;
      longint sum;
      bit     cfgn;
      @(negedge clk);
      cyc++;
      // ---- output side ----
      if (out_valid) begin
         if (sb_q.size() == 0) begin
            check_val("spurious_out_valid", out_valid, 0);
         end else begin
            e = sb_q.pop_front();
            check_val("out_data", out_data, e.d);
            check_val("sat_hi", sat_hi, e.sh);
            check_val("sat_lo", sat_lo, e.sl);
            check_val("latency", cyc - e.cyc, 2);
            $display("out cyc=%0d data=%0d sat_hi=%0b sat_lo=%0b", cyc, out_data, sat_hi, sat_lo);
         end
      end else if (sb_q.size() != 0 && (cyc - sb_q[0].cyc) >= 2) begin
         check_val("missing_out_valid", out_valid, 1);
         void'(sb_q.pop_front());
      end
      check_val("ov_sticky", ov_sticky, m_ov);
      check_val("cfg_err", cfg_err, m_cfg);
      // ---- input side ----
      rst      = r;
      in_valid = v;
      in_data  = d[15:0];
      in_ov    = o;
      clr      = c;
      hold     = h;
      lim_hi   = hi_l[23:0];
      lim_lo   = lo_l[23:0];
      if (r) begin
         sb_q.delete();
         m_acc = 0; m_sh = 0; m_sl = 0; m_ov = 0; m_cfg = 0;
      end else begin
         cfgn  = (lo_l > hi_l);
         m_cfg = cfgn;
         if (c) begin
            m_acc = 0; m_sh = 0; m_sl = 0; m_ov = 0;
         end else if (cfgn) begin
            m_acc = 0; m_sh = 0; m_sl = 0;
         end else if (h) begin
            // accumulator frozen
         end else if (v) begin
            sum = m_acc + d;
            if (sum > hi_l)      begin m_acc = hi_l; m_sh = 1; m_sl = 0; end
            else if (sum < lo_l) begin m_acc = lo_l; m_sh = 0; m_sl = 1; end
            else                 begin m_acc = sum;  m_sh = 0; m_sl = 0; end
            if (o) m_ov = 1;
         end
         if (v) begin
            e.d   = out_scale(m_acc);
            e.sh  = m_sh;
            e.sl  = m_sl;
            e.cyc = cyc;
            sb_q.push_back(e);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic sample(input longint d);
      step(0, 1, d, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ov = 1'b0;
      clr = 1'b0; hold = 1'b0;
      lim_hi = LIM_MAX[23:0]; lim_lo = LIM_MIN[23:0];

      // Reset state
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_out_data", out_data, 0);
      check_val("rst_sat_hi", sat_hi, 0);
      check_val("rst_sat_lo", sat_lo, 0);
      check_val("rst_ov_sticky", ov_sticky, 0);
      check_val("rst_cfg_err", cfg_err, 0);

      // Back-to-back 256, 512, -256 -> 1, 3, 2
      sample(256); sample(512); sample(-256);
      idle(3);

      // Reset mid-stream discards in-flight samples
      step(0, 1, 1000, 1, 0, 0);
      sample(2000);
      step(1, 1, 3000, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      idle(3);
      check_val("rst_mid_ov_sticky", ov_sticky, 0);
      sample(256);  // accumulator restarted from zero -> 1
      idle(3);

      // Upper limit: 600, 600, -100 with lim_hi=1000
      step(0, 0, 0, 0, 1, 0);
      hi_l = 1000;
      sample(600); sample(600); sample(-100);
      idle(3);
      hi_l = LIM_MAX;

      // Lower limit and leaving it on the first opposite sample
      lo_l = -700;
      sample(-500); sample(-500); sample(-500); sample(300);
      idle(3);
      lo_l = LIM_MIN;

      // clr together with a sample after acc=768
      step(0, 0, 0, 0, 1, 0);
      sample(256); sample(512);
      step(0, 1, 512, 1, 1, 0);
      idle(3);

      // Hold: frozen accumulator still produces outputs
      sample(1024);
      step(0, 1, 4096, 0, 0, 1);
      step(0, 1, 4096, 0, 0, 1);
      sample(-512);
      idle(3);

      // ov_sticky survives clean samples until clr
      step(0, 1, 10, 1, 0, 0);
      for (int i = 0; i < 10; i++) sample(5);
      idle(2);
      step(0, 0, 0, 0, 1, 0);
      idle(2);

      // Inverted limits -> cfg_err, accumulator zeroed; then recovery
      sample(2560);
      lo_l = 5; hi_l = -5;
      sample(700);
      sample(700);
      lo_l = LIM_MIN; hi_l = LIM_MAX;
      sample(512); sample(256);
      idle(3);

      // Randomised traffic with tight, changing limits
      for (int i = 0; i < 400; i++) begin
         if (i % 50 == 0) begin
            hi_l = longint'($urandom_range(0, 200000));
            lo_l = -longint'($urandom_range(0, 200000));
            if ($urandom_range(0, 4) == 0) begin
               hi_l = -hi_l - 1;
               lo_l = -lo_l + 1;
            end
         end
         if (i % 50 == 10 && lo_l > hi_l) begin
            hi_l = LIM_MAX; lo_l = LIM_MIN;
         end
         step(($urandom_range(0, 150) == 0),
              ($urandom_range(0, 3) != 0),
              longint'($urandom_range(0, 65535)) - 32768,
              ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 40) == 0),
              ($urandom_range(0, 7) == 0));
      end

      idle(4);
      check_val("drain_empty", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
